// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register of the RV32I core.
//   Keeps the fetch PC and has at most one request in flight to instruction
//   memory. Each returned word is registered with its PC and PC+4 for decode.
//   A decode stall that arrives while a response is in flight is absorbed by a
//   one-entry skid buffer (state HOLD). A redirect from EX flushes IF/ID and
//   marks any in-flight response as stale so that it is discarded on arrival.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   imem_req_valid    request valid (REQ state only, forced low during reset)
//   imem_req_ready    memory accepts the request this cycle
//   imem_addr         word-aligned fetch address
//   imem_rsp_valid    one-cycle response pulse per accepted request
//   imem_rsp_data     returned instruction word
//   id_stall          decode cannot take a new instruction this cycle
//   redirect_valid    taken branch/jump pulse from EX
//   redirect_pc       new fetch target (low two bits ignored)
//   if_id_valid       IF/ID holds a real instruction
//   if_id_ir          instruction to decode (NOP_INSTR when invalid)
//   if_id_pc          PC of if_id_ir
//   if_id_pc4         if_id_pc + 4 (modulo 2^32)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_ir,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] req_pc_q,    req_pc_d;
    logic        drop_q,      drop_d;
    logic [31:0] skid_ir_q,   skid_ir_d;
    logic [31:0] skid_pc_q,   skid_pc_d;
    logic        ifid_v_q,    ifid_v_d;
    logic [31:0] ifid_ir_q,   ifid_ir_d;
    logic [31:0] ifid_pc_q,   ifid_pc_d;
    logic [31:0] ifid_pc4_q,  ifid_pc4_d;

    logic [31:0] req_pc_plus4;
    logic [31:0] skid_pc_plus4;
    logic        slot_free;

    assign req_pc_plus4  = req_pc_q + 32'd4;
    assign skid_pc_plus4 = skid_pc_q + 32'd4;
    // IF/ID can take a new word if it is empty or decode consumes it now.
    assign slot_free     = !ifid_v_q || !id_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            drop_q     <= 1'b0;
            skid_ir_q  <= NOP_INSTR;
            skid_pc_q  <= 32'd0;
            ifid_v_q   <= 1'b0;
            ifid_ir_q  <= NOP_INSTR;
            ifid_pc_q  <= 32'd0;
            ifid_pc4_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            skid_ir_q  <= skid_ir_d;
            skid_pc_q  <= skid_pc_d;
            ifid_v_q   <= ifid_v_d;
            ifid_ir_q  <= ifid_ir_d;
            ifid_pc_q  <= ifid_pc_d;
            ifid_pc4_q <= ifid_pc4_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        skid_ir_d  = skid_ir_q;
        skid_pc_d  = skid_pc_q;
        ifid_v_d   = ifid_v_q;
        ifid_ir_d  = ifid_ir_q;
        ifid_pc_d  = ifid_pc_q;
        ifid_pc4_d = ifid_pc4_q;

        // Decode consumed the current entry and nothing new arrives: bubble.
        // PC fields are left alone so they keep their last value.
        if (!id_stall) begin
            ifid_v_d  = 1'b0;
            ifid_ir_d = NOP_INSTR;
        end

        if (redirect_valid) begin
            // Redirect wins over everything, including a decode stall.
            pc_d      = {redirect_pc[31:2], 2'b00};
            ifid_v_d  = 1'b0;
            ifid_ir_d = NOP_INSTR;
            skid_ir_d = NOP_INSTR;
            state_d   = S_REQ;
            drop_d    = 1'b0;
            unique case (state_q)
                S_REQ: begin
                    // The old request still goes out; its reply must be dropped.
                    if (imem_req_ready) begin
                        req_pc_d = pc_q;
                        state_d  = S_WAIT;
                        drop_d   = 1'b1;
                    end
                end
                S_WAIT: begin
                    // No reply yet: keep waiting so the one-outstanding rule
                    // holds, and throw the reply away when it comes.
                    if (!imem_rsp_valid) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_req_ready) begin
                        req_pc_d = pc_q;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_d = S_REQ;
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else if (slot_free) begin
                            ifid_v_d   = 1'b1;
                            ifid_ir_d  = imem_rsp_data;
                            ifid_pc_d  = req_pc_q;
                            ifid_pc4_d = req_pc_plus4;
                            pc_d       = req_pc_plus4;
                        end else begin
                            skid_ir_d = imem_rsp_data;
                            skid_pc_d = req_pc_q;
                            pc_d      = req_pc_plus4;
                            state_d   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!id_stall) begin
                        ifid_v_d   = 1'b1;
                        ifid_ir_d  = skid_ir_q;
                        ifid_pc_d  = skid_pc_q;
                        ifid_pc4_d = skid_pc_plus4;
                        state_d    = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // Request is gated by rst so nothing is offered while reset is held.
    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_addr      = pc_q;
    assign if_id_valid    = ifid_v_q;
    assign if_id_ir       = ifid_ir_q;
    assign if_id_pc       = ifid_pc_q;
    assign if_id_pc4      = ifid_pc4_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the pipelined RV32I core.
- Holds the PC and issues one request at a time to instruction memory.
- Registers the returned instruction word with its PC and PC+4 for the decode stage; decode drives its IR input (feeding the immediate generator) from these outputs.
- Handles decode stalls with a one-entry skid buffer, and control-flow redirects by flushing IF/ID and discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0033, bubble instruction (add x0,x0,x0) placed in IF/ID when invalid.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  32  fetch address, bits [1:0] always 00
imem_rsp_valid  input  1  response valid, one cycle pulse per accepted request
imem_rsp_data  input  32  instruction word
id_stall  input  1  decode cannot accept a new instruction this cycle
redirect_valid  input  1  taken branch/jump from EX, one-cycle pulse
redirect_pc  input  32  new fetch target
if_id_valid  output  1  IF/ID holds a real instruction
if_id_ir  output  32  instruction to decode
if_id_pc  output  32  PC of if_id_ir
if_id_pc4  output  32  if_id_pc + 4

Behaviour:
- Reset (async, rst=1) sets:
  - pc = RESET_PC; state = REQ; drop = 0; skid empty.
  - if_id_valid = 0, if_id_ir = NOP_INSTR, if_id_pc = 0, if_id_pc4 = 0.
  - imem_req_valid = 0 while rst is high.
- Reset mid-request abandons it; the memory must not respond to requests outstanding across reset.
- FSM states: REQ, WAIT, HOLD.
  - REQ:
    - imem_req_valid=1, imem_addr=pc.
    - On imem_req_ready: req_pc<=pc, go WAIT.
    - Address stays stable until accepted, unless a redirect occurs.
  - WAIT:
    - imem_req_valid=0. Wait for imem_rsp_valid.
    - If drop=1: discard response, drop<=0, go REQ.
    - Else if the slot is free (if_id_valid=0 or id_stall=0): load if_id_ir=rsp_data, if_id_pc=req_pc, if_id_pc4=req_pc+4, if_id_valid=1; pc<=req_pc+4; go REQ.
    - Else write the skid buffer, pc<=req_pc+4, go HOLD.
  - HOLD:
    - imem_req_valid=0.
    - When id_stall=0: move skid into IF/ID, go REQ.
- IF/ID when no new instruction is loaded:
  - id_stall=1 with if_id_valid=1: hold all fields.
  - id_stall=0: if_id_valid<=0, if_id_ir<=NOP_INSTR; pc fields hold.
- Latency: request accepted in cycle N, response in cycle M ≥ N+1, IF/ID valid in M+1 when not stalled. Peak throughput is one instruction per 2 cycles with single-cycle memory.
- Redirect (highest priority, overrides id_stall):
  - pc<=redirect_pc with bits [1:0] forced to 00.
  - if_id_valid<=0, if_id_ir<=NOP_INSTR; skid cleared; next state REQ.
  - In WAIT with no response this cycle: drop<=1, stay WAIT.
  - In WAIT with a response in the same cycle: response discarded, go REQ.
  - In REQ with imem_req_ready the same cycle: the old request is accepted; go WAIT with drop=1.
  - In HOLD: skid discarded, go REQ.
- Arithmetic: PC+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
- imem_rsp_valid outside WAIT is ignored.
- At most one request outstanding at any time.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait memory returning 0x00500093 at 0x100 → first imem_addr=0x100; if_id_ir=0x00500093, if_id_pc=0x100, if_id_pc4=0x104, if_id_valid=1; next address 0x104.
- id_stall held 3 cycles while a response for 0x104 arrives → IF/ID keeps the 0x100 instruction, FSM in HOLD, no request; on release, IF/ID shows 0x104, then a request to 0x108.
- Redirect to 0x200 while WAIT for 0x108, response 2 cycles later → response dropped, IF/ID bubble (NOP_INSTR, valid=0), next request addr 0x200, no 0x108 instruction ever valid.
- Redirect in the same cycle as imem_rsp_valid, and in the same cycle as imem_req_ready → both stale instructions discarded; fetch resumes at redirect_pc.
- redirect_pc=0x303 → imem_addr=0x300; pc at 0xFFFF_FFFC → if_id_pc4=0, next addr 0.
- Assert rst while in WAIT → outputs return to reset values immediately (asynchronously), and fetch restarts at RESET_PC after release.
